// File: rtl/apb_pkg.sv
// Shared APB slave definitions: FSM state encoding, fixed ID word and alignment mask.
// Pure declarations; no logic of its own.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic [31:0] REG_ID          = 32'hA5B0_0001;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'h0000_0003;

  function automatic logic misaligned(input logic [31:0] addr);
    return (addr & ADDR_ALIGN_MASK) != 32'h0;
  endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a requester (master) and a register-file slave.
// Pure wiring; timing and backpressure are owned by the endpoints.
interface apb_slave_regfile_if;
  logic        pwrite;
  logic        penable;
  logic [2:0]  psel;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output pwrite, penable, psel, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  pwrite, penable, psel, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_reg_bank.sv
// Register array with a read-only ID word in the top slot; writes land on the clock edge.
// Read data is combinational from the index; no backpressure, wr_en is trusted.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             Hclk,
  input  logic             Hresetn,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic [31:0] regs [NUM_REGS];

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (wr_en && idx != LAST_IDX) begin
      regs[idx] <= wdata;
    end
  end

  assign rdata = (idx == LAST_IDX) ? REG_ID : regs[idx];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB register-file slave: IDLE/SETUP/ACCESS FSM, programmable wait states, error decode.
// pready rises WAIT_STATES cycles into ACCESS; dropping psel mid-access aborts with no side effects.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int SEL_INDEX   = 0,
  parameter int NUM_REGS    = 16
) (
  input  logic                Hclk,
  input  logic                Hresetn,
  apb_slave_regfile_if.slave  bus,
  output logic [7:0]          wr_count
);

  localparam int               IDX_W      = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REGS - 1);
  localparam logic [31:0]      ADDR_LIMIT = 32'(4 * NUM_REGS);

  apb_state_t       state, state_nxt;
  logic [3:0]       wait_cnt;
  logic [31:0]      addr_q;
  logic             write_q;
  logic             sel, ready, err, wr_en;
  logic [IDX_W-1:0] idx;
  logic [31:0]      bank_rdata;
  logic [2:0]       psel_unused;

  // Other select bits belong to sibling slaves on the same bus.
  assign psel_unused = bus.psel;
  assign sel         = bus.psel[SEL_INDEX];

  assign ready = (state == ACCESS) && (wait_cnt == 4'd0);
  assign idx   = addr_q[IDX_W+1:2];
  assign err   = misaligned(addr_q) || (addr_q >= ADDR_LIMIT) ||
                 (write_q && idx == LAST_IDX);
  assign wr_en = ready && sel && bus.penable && write_q && !err;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (sel && !bus.penable) state_nxt = SETUP;
      SETUP:  if (!sel) state_nxt = IDLE;
              else if (bus.penable) state_nxt = ACCESS;
      ACCESS: if (!sel || (ready && bus.penable)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= 32'h0;
      write_q  <= 1'b0;
      wr_count <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == SETUP) begin
        addr_q   <= bus.paddr;
        write_q  <= bus.pwrite;
        wait_cnt <= 4'(WAIT_STATES);
      end else if (state == ACCESS && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (wr_en) wr_count <= wr_count + 8'd1;
    end
  end

  apb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .wr_en   (wr_en),
    .idx     (idx),
    .wdata   (bus.pwdata),
    .rdata   (bank_rdata)
  );

  assign bus.pready  = ready;
  assign bus.pslverr = ready && err;
  assign bus.prdata  = (ready && !write_q && !err) ? bank_rdata : 32'h0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Three slaves share one APB bus (WAIT_STATES 0/1/3 on psel bits 0/1/2); directed transfers
// with hand-computed results for timing, data, errors, abort and asynchronous reset.
module tb_apb_slave_regfile;
  import apb_pkg::*;

  logic        Hclk;
  logic        Hresetn;
  logic        pwrite, penable;
  logic [2:0]  psel;
  logic [31:0] paddr, pwdata;
  logic [7:0]  wr0, wr1, wr3;

  int          tgt;
  logic        t_pready, t_pslverr;
  logic [31:0] t_prdata;

  int n_tests = 0;
  int n_fail  = 0;

  apb_slave_regfile_if bus0();
  apb_slave_regfile_if bus1();
  apb_slave_regfile_if bus3();

  assign bus0.pwrite = pwrite;  assign bus0.penable = penable; assign bus0.psel = psel;
  assign bus0.paddr  = paddr;   assign bus0.pwdata  = pwdata;
  assign bus1.pwrite = pwrite;  assign bus1.penable = penable; assign bus1.psel = psel;
  assign bus1.paddr  = paddr;   assign bus1.pwdata  = pwdata;
  assign bus3.pwrite = pwrite;  assign bus3.penable = penable; assign bus3.psel = psel;
  assign bus3.paddr  = paddr;   assign bus3.pwdata  = pwdata;

  apb_slave_regfile #(.WAIT_STATES(0), .SEL_INDEX(0), .NUM_REGS(16)) u_dut0 (
    .Hclk(Hclk), .Hresetn(Hresetn), .bus(bus0.slave), .wr_count(wr0));
  apb_slave_regfile #(.WAIT_STATES(1), .SEL_INDEX(1), .NUM_REGS(16)) u_dut1 (
    .Hclk(Hclk), .Hresetn(Hresetn), .bus(bus1.slave), .wr_count(wr1));
  apb_slave_regfile #(.WAIT_STATES(3), .SEL_INDEX(2), .NUM_REGS(16)) u_dut3 (
    .Hclk(Hclk), .Hresetn(Hresetn), .bus(bus3.slave), .wr_count(wr3));

  always_comb begin
    t_pready  = bus0.pready;
    t_pslverr = bus0.pslverr;
    t_prdata  = bus0.prdata;
    if (tgt == 1) begin
      t_pready = bus1.pready; t_pslverr = bus1.pslverr; t_prdata = bus1.prdata;
    end else if (tgt == 2) begin
      t_pready = bus3.pready; t_pslverr = bus3.pslverr; t_prdata = bus3.prdata;
    end
  end

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full APB transfer to slave t; returns data/error seen with pready and the cycle
  // (counted from the setup-accept edge) in which pready was first observed.
  task automatic xfer(input int t, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd,
                      output logic err, output int cyc);
    tgt = t; psel = 3'(1 << t); penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge Hclk); #1;
    penable = 1'b1;
    cyc = 1;
    @(negedge Hclk);
    while (!t_pready && cyc < 40) begin
      @(posedge Hclk); #1;
      cyc++;
      @(negedge Hclk);
    end
    rd  = t_prdata;
    err = t_pslverr;
    @(posedge Hclk); #1;
    psel = 3'b000; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          cyc;
    logic        saw;

    Hresetn = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; tgt = 1;
    repeat (2) @(posedge Hclk);
    @(negedge Hclk);
    check("rst_pready",  32'(t_pready), 32'd0);
    check("rst_pslverr", 32'(t_pslverr), 32'd0);
    check("rst_prdata",  t_prdata, 32'h0);
    check("rst_wr_count", 32'(wr1), 32'd0);
    Hresetn = 1'b1;
    @(posedge Hclk); #1;

    // WAIT_STATES=1: write then read back
    xfer(1, 1'b1, 32'h08, 32'h1234_5678, rd, err, cyc);
    check("w1_cycles", 32'(cyc), 32'd3);
    check("w1_err",    32'(err), 32'd0);
    check("w1_prdata_on_write", rd, 32'h0);
    xfer(1, 1'b0, 32'h08, 32'h0, rd, err, cyc);
    check("r1_cycles", 32'(cyc), 32'd3);
    check("r1_data",   rd, 32'h1234_5678);
    check("r1_err",    32'(err), 32'd0);
    check("w1_count",  32'(wr1), 32'd1);

    // Error responses: ID write, misaligned write, out-of-range read
    xfer(1, 1'b1, 32'h3C, 32'hFFFF_FFFF, rd, err, cyc);
    check("id_write_err", 32'(err), 32'd1);
    xfer(1, 1'b1, 32'h05, 32'h0BAD_0BAD, rd, err, cyc);
    check("misalign_err", 32'(err), 32'd1);
    xfer(1, 1'b0, 32'h3C, 32'h0, rd, err, cyc);
    check("id_read",     rd, 32'hA5B0_0001);
    check("id_read_err", 32'(err), 32'd0);
    check("err_count",   32'(wr1), 32'd1);
    xfer(1, 1'b0, 32'h04, 32'h0, rd, err, cyc);
    check("misalign_no_write", rd, 32'h0);
    xfer(1, 1'b0, 32'h40, 32'h0, rd, err, cyc);
    check("oor_err",    32'(err), 32'd1);
    check("oor_prdata", rd, 32'h0);

    // WAIT_STATES=0: back-to-back writes, then readback
    xfer(0, 1'b1, 32'h00, 32'h1111_1111, rd, err, cyc);
    check("b2b_cyc0", 32'(cyc), 32'd2);
    xfer(0, 1'b1, 32'h04, 32'h2222_2222, rd, err, cyc);
    check("b2b_cyc1", 32'(cyc), 32'd2);
    xfer(0, 1'b1, 32'h08, 32'h3333_3333, rd, err, cyc);
    check("b2b_cyc2", 32'(cyc), 32'd2);
    check("b2b_count", 32'(wr0), 32'd3);
    xfer(0, 1'b0, 32'h00, 32'h0, rd, err, cyc);
    check("b2b_rd0", rd, 32'h1111_1111);
    xfer(0, 1'b0, 32'h04, 32'h0, rd, err, cyc);
    check("b2b_rd1", rd, 32'h2222_2222);
    xfer(0, 1'b0, 32'h08, 32'h0, rd, err, cyc);
    check("b2b_rd2", rd, 32'h3333_3333);
    check("b2b_rd_cyc", 32'(cyc), 32'd2);

    // WAIT_STATES=3: good write, then aborted write to the same register
    xfer(2, 1'b1, 32'h10, 32'hCAFE_0001, rd, err, cyc);
    check("w3_cycles", 32'(cyc), 32'd5);
    tgt = 2; psel = 3'b100; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h10; pwdata = 32'hDEAD_BEEF; saw = 1'b0;
    @(posedge Hclk); #1;
    penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Hclk);
      if (t_pready) saw = 1'b1;
      @(posedge Hclk); #1;
    end
    psel = 3'b000; penable = 1'b0;
    @(negedge Hclk);
    if (t_pready) saw = 1'b1;
    @(posedge Hclk); #1;
    check("abort_pready", 32'(saw), 32'd0);
    check("abort_state",  32'(u_dut3.state), 32'(IDLE));
    check("abort_count",  32'(wr3), 32'd1);
    xfer(2, 1'b0, 32'h10, 32'h0, rd, err, cyc);
    check("abort_reg", rd, 32'hCAFE_0001);

    // Asynchronous reset in the middle of an ACCESS on the WAIT_STATES=1 slave
    tgt = 1; psel = 3'b010; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h0C; pwdata = 32'h0000_0055;
    @(posedge Hclk); #1;
    penable = 1'b1;
    @(posedge Hclk); #1;
    check("pre_rst_state", 32'(u_dut1.state), 32'(ACCESS));
    #2;
    Hresetn = 1'b0;
    #1;
    check("arst_state",   32'(u_dut1.state), 32'(IDLE));
    check("arst_pready",  32'(t_pready), 32'd0);
    check("arst_pslverr", 32'(t_pslverr), 32'd0);
    check("arst_prdata",  t_prdata, 32'h0);
    check("arst_count1",  32'(wr1), 32'd0);
    check("arst_count0",  32'(wr0), 32'd0);
    psel = 3'b000; penable = 1'b0;
    @(negedge Hclk);
    Hresetn = 1'b1;
    @(posedge Hclk); #1;
    xfer(1, 1'b0, 32'h08, 32'h0, rd, err, cyc);
    check("arst_reg1", rd, 32'h0);
    xfer(0, 1'b0, 32'h04, 32'h0, rd, err, cyc);
    check("arst_reg0", rd, 32'h0);
    xfer(1, 1'b0, 32'h3C, 32'h0, rd, err, cyc);
    check("arst_id", rd, 32'hA5B0_0001);

    // 256 writes wrap the counter
    for (int i = 0; i < 256; i++) begin
      xfer(0, 1'b1, 32'h0C, 32'(i), rd, err, cyc);
      if (i == 254) check("wrap_255", 32'(wr0), 32'd255);
    end
    check("wrap_0", 32'(wr0), 32'd0);
    xfer(0, 1'b0, 32'h0C, 32'h0, rd, err, cyc);
    check("wrap_data", rd, 32'h0000_00FF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, giving access-phase wait cycles before PREADY (range 0-15).
REQ-002 SHALL have parameter SEL_INDEX, default 0, selecting which psel bit addresses this slave.
REQ-003 SHALL have parameter NUM_REGS, default 16, giving the number of 32-bit registers (power of 2, 2-16).
REQ-004 Hclk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Hresetn  input  1  asynchronous, active-low reset.
REQ-006 pwrite  input  1  1=write, 0=read; sampled in setup and access phases.
REQ-007 penable  input  1  APB access-phase strobe.
REQ-008 psel  input  3  one-hot slave selects; only psel[SEL_INDEX] is used.
REQ-009 paddr  input  32  byte address.
REQ-010 pwdata  input  32  write data.
REQ-011 prdata  output  32  read data.
REQ-012 pready  output  1  transfer-complete indication.
REQ-013 pslverr  output  1  error response, valid only while pready=1.
REQ-014 wr_count  output  8  count of completed error-free writes.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-016 IDLE->SETUP when psel[SEL_INDEX]=1 and penable=0 at a clock edge; otherwise stays IDLE, including when penable=1 arrives with no prior setup.
REQ-017 On entering SETUP, SHALL latch paddr and pwrite and load wait counter with WAIT_STATES.
REQ-018 SETUP->ACCESS when psel[SEL_INDEX]=1 and penable=1; SETUP->IDLE if psel[SEL_INDEX]=0.
REQ-019 In ACCESS with counter non-zero, SHALL decrement the counter each cycle with pready=0.
REQ-020 pready SHALL be 1 exactly when state=ACCESS and counter=0; for WAIT_STATES=0 the transfer completes in the first access cycle (two-cycle transfer); otherwise it takes 2+WAIT_STATES cycles.
REQ-021 Transfer completes at the edge where psel[SEL_INDEX], penable and pready are all 1; ACCESS->IDLE at that edge.
REQ-022 If psel[SEL_INDEX] drops during ACCESS before completion, SHALL abort to IDLE with no register write and no wr_count change.
REQ-023 Register index = latched paddr[5:2] masked to log2(NUM_REGS) bits.
REQ-024 Error condition: latched paddr[1:0]!=0, or latched paddr >= 4*NUM_REGS, or a write to index NUM_REGS-1.
REQ-025 pslverr SHALL equal the error condition while pready=1, else 0.
REQ-026 Error-free write: register[index] <= pwdata at the completion edge; wr_count increments by 1, wrapping 255->0.
REQ-027 Erroring write: no register change, no wr_count change.
REQ-028 Index NUM_REGS-1 is read-only, hard-wired to 32'hA5B0_0001.
REQ-029 prdata SHALL be register[index] while pready=1, latched pwrite=0 and no error; 32'h0 at all other times.
REQ-030 A back-to-back setup in the cycle after completion SHALL be accepted from IDLE with no dead cycle beyond REQ-016.

Reset
REQ-031 Hresetn=0 SHALL immediately force state IDLE, counter 0, pready 0, pslverr 0, prdata 0, wr_count 0, and all writable registers 32'h0, regardless of any transfer in progress.
REQ-032 After release, first setup is accepted at the first rising edge with Hresetn=1.

Structure
REQ-033 FSM state encoding, the ID constant 32'hA5B0_0001 and the address-alignment mask SHALL live in a shared package apb_pkg.
REQ-034 Register array and read mux SHALL be a sub-module apb_reg_bank (write enable, index, wdata in; rdata out); FSM, counter and error decode stay in the top.

Verification
REQ-035 WAIT_STATES=1: write 0x1234_5678 to paddr 0x08, then read 0x08 -> pready high in 3rd cycle of each transfer, prdata=0x1234_5678, pslverr=0, wr_count=1.
REQ-036 WAIT_STATES=0: back-to-back writes to 0x00, 0x04, 0x08 -> each completes in 2 cycles, wr_count=3, readback matches.
REQ-037 Write to 0x3C (ID) and to 0x05 (misaligned) -> pslverr=1 with pready, ID still reads 0xA5B0_0001, wr_count unchanged.
REQ-038 Read of paddr 0x40 with NUM_REGS=16 -> pslverr=1, prdata=0.
REQ-039 WAIT_STATES=3: deassert psel mid-ACCESS during write to 0x10 -> FSM IDLE, reg 0x10 unchanged, pready never asserted.
REQ-040 Assert Hresetn=0 mid-ACCESS after prior writes -> outputs and registers zero asynchronously; 256 writes wrap wr_count to 0.
